uart_image_loader: RTL and testbench

//   Receives a 784-pixel binary image (28x28) as 98 UART bytes, unpacks it bit-serially into an

---
 rtl/snn_pkg.sv | 22 ++
 rtl/uart_image_loader_if.sv | 24 ++
 rtl/uart_image_loader_input_bit_ram.sv | 30 +++
 rtl/uart_image_loader.sv | 124 ++++++++++++
 tb/tb_uart_image_loader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and sizing for the UART image loader and the SNN core that reads its RAM.
package snn_pkg;

  localparam int IMG_BITS_C  = 784;
  localparam int IMG_BYTES_C = 98;
  localparam int ADDR_W      = 10;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    RECV,
    DONE,
    WAIT
  } loader_state_t;

  // Pixel address of bit i of byte k is 8*k+i, i.e. a plain concatenation.
  function automatic logic [ADDR_W-1:0] bit_addr(input logic [6:0] byte_idx,
                                                 input logic [2:0] bit_idx);
    return {byte_idx, bit_idx};
  endfunction

endpackage

// File: rtl/uart_image_loader_if.sv
// Byte-stream / core-side signal bundle of the image loader; slave = loader, master = driver.
interface uart_image_loader_if;
  import snn_pkg::*;

  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              core_done;
  logic [ADDR_W-1:0] addr;
  logic              q;
  logic              ready;
  logic              busy;
  logic              overrun;

  modport master (
    output rx_rdy, rx_data, core_done, addr,
    input  q, ready, busy, overrun
  );

  modport slave (
    input  rx_rdy, rx_data, core_done, addr,
    output q, ready, busy, overrun
  );

endinterface

// File: rtl/uart_image_loader_input_bit_ram.sv
// 1-bit wide pixel RAM: one synchronous write port, one registered read port.
// Out-of-range read addresses return 0; contents survive reset, only q is reset.
module input_bit_ram #(
    parameter int DEPTH = 784,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] raddr,
    output logic          q
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             q <= 1'b0;
        else if (raddr <= LAST) q <= mem[raddr];
        else                    q <= 1'b0;
    end

endmodule

// File: rtl/uart_image_loader.sv
// Collects a binary image from UART bytes into a bit RAM and hands it to the SNN core.
// Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
module uart_image_loader
    import snn_pkg::*;
#(
    parameter int IMG_BITS = IMG_BITS_C
`ifdef LOADER_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 5_000_000
`endif
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_image_loader_if.slave  bus
);

    localparam int         IMG_BYTES = IMG_BITS / 8;
    localparam logic [6:0] LAST_BYTE = 7'(IMG_BYTES - 1);

    loader_state_t state_q, state_d;
    logic [7:0]    shreg;
    logic [6:0]    byte_cnt;
    logic [2:0]    bit_cnt;
    logic          overrun_q;
    logic          timeout;
    logic          ram_we;
    logic          ready;
    logic          busy;
    logic          load;
    logic          drop;

    assign load = bus.rx_rdy && (state_q == IDLE || state_q == RECV);
    // Any byte arriving while unpacking or while the core owns the RAM is lost.
    assign drop = bus.rx_rdy && (state_q == UNPACK || state_q == DONE || state_q == WAIT);

`ifdef LOADER_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    logic [GAP_W-1:0] gap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             gap_q <= '0;
        else if (state_q != RECV || bus.rx_rdy) gap_q <= '0;
        else                                    gap_q <= gap_q + 1'b1;
    end

    assign timeout = (state_q == RECV) && !bus.rx_rdy && (gap_q == GAP_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.rx_rdy) state_d = UNPACK;
            UNPACK:  if (bit_cnt == 3'd7) state_d = (byte_cnt == LAST_BYTE) ? DONE : RECV;
            RECV:    if (bus.rx_rdy)   state_d = UNPACK;
                     else if (timeout) state_d = IDLE;
            DONE:    state_d = WAIT;
            WAIT:    if (bus.core_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        busy   = 1'b1;
        ram_we = 1'b0;
        case (state_q)
            IDLE:    busy   = 1'b0;
            UNPACK:  ram_we = 1'b1;
            DONE:    ready  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            shreg <= bus.rx_data;
            if (state_q == IDLE) begin
                byte_cnt <= '0;
                bit_cnt  <= '0;
            end
        end else if (state_q == UNPACK) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 7'd1;
        end
    end

    // A drop on the final unpack cycle still reports, so set wins over the clear on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      overrun_q <= 1'b0;
        else if (drop || timeout)                        overrun_q <= 1'b1;
        else if (state_d == DONE && state_q != DONE)     overrun_q <= 1'b0;
    end

    input_bit_ram #(
        .DEPTH (IMG_BITS),
        .AW    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (bit_addr(byte_cnt, bit_cnt)),
        .wdata (shreg[0]),
        .raddr (bus.addr),
        .q     (bus.q)
    );

    assign bus.ready   = ready;
    assign bus.busy    = busy;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_uart_image_loader.sv
// Bench for uart_image_loader: table vectors, hand sequences and random frames vs a frame-level model.
module tb_uart_image_loader;
  import snn_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_image_loader_if bus();

`ifdef LOADER_TIMEOUT_EN
  localparam int TO = 200;
  uart_image_loader #(.IMG_BITS(IMG_BITS_C), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`else
  uart_image_loader #(.IMG_BITS(IMG_BITS_C)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Frame-level reference: bytes land in pixel order until a frame completes, then lock.
  bit   m_ram [IMG_BITS_C];
  int   m_idx = 0;
  bit   m_locked = 0;
  bit   m_ovr = 0;
  logic [7:0] frame [IMG_BYTES_C];

  typedef struct {
    int         frm;
    logic [9:0] addr;
    logic       q;
  } rd_vec_t;
  rd_vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit model_byte(input logic [7:0] b);
    if (m_locked) begin
      m_ovr = 1;
      return 0;
    end
    for (int i = 0; i < 8; i++) m_ram[8*m_idx+i] = b[i];
    m_idx++;
    if (m_idx == IMG_BYTES_C) begin
      m_idx = 0;
      m_locked = 1;
      m_ovr = 0;
      return 1;
    end
    return 0;
  endfunction

  function automatic bit model_busy();
    return m_locked || (m_idx > 0);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit   exp_r;
    int   pulses = 0;
    int   pos = 0;
    logic ovr_r = 1'b1;
    exp_r = model_byte(b);
    @(negedge clk); bus.rx_rdy = 1'b1; bus.rx_data = b;
    @(negedge clk); bus.rx_rdy = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (bus.ready === 1'b1) begin
        pulses++;
        pos = k;
        ovr_r = bus.overrun;
      end
      @(negedge clk);
    end
    chk("ready_pulse(count*16+cycle)", pulses * 16 + pos, exp_r ? 32'd25 : 32'd0);
    if (exp_r) chk("overrun_at_ready", ovr_r, 0);
  endtask

  task automatic send_frame();
    for (int i = 0; i < IMG_BYTES_C; i++) send_byte(frame[i]);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < IMG_BYTES_C; i++) frame[i] = 8'($urandom);
  endtask

  task automatic read_chk(input string nm, input logic [9:0] a, input logic exp);
    @(negedge clk); bus.addr = a;
    @(negedge clk); chk(nm, bus.q, exp);
  endtask

  task automatic rand_reads(input int n);
    logic [9:0] a;
    for (int i = 0; i < n; i++) begin
      a = 10'($urandom_range(0, 1023));
      read_chk("ram_read", a, (a < 10'(IMG_BITS_C)) ? m_ram[a] : 1'b0);
    end
  endtask

  task automatic apply_table(input int frm);
    for (int i = 0; i < 14; i++)
      if (vecs[i].frm == frm) read_chk("table_read", vecs[i].addr, vecs[i].q);
  endtask

  task automatic pulse_done();
    @(negedge clk); bus.core_done = 1'b1;
    @(negedge clk); bus.core_done = 1'b0;
    m_locked = 0;
    chk("busy_after_done", bus.busy, model_busy());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1, 10'd0, 1'b1};   vecs[1]  = '{1, 10'd1, 1'b0};
    vecs[2]  = '{1, 10'd2, 1'b1};   vecs[3]  = '{1, 10'd3, 1'b0};
    vecs[4]  = '{1, 10'd4, 1'b0};   vecs[5]  = '{1, 10'd5, 1'b1};
    vecs[6]  = '{1, 10'd6, 1'b0};   vecs[7]  = '{1, 10'd7, 1'b1};
    vecs[8]  = '{2, 10'd0, 1'b1};   vecs[9]  = '{2, 10'd1, 1'b0};
    vecs[10] = '{2, 10'd8, 1'b0};   vecs[11] = '{2, 10'd782, 1'b0};
    vecs[12] = '{2, 10'd783, 1'b1}; vecs[13] = '{2, 10'd800, 1'b0};

    bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.core_done = 1'b0; bus.addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs{ready,busy,overrun,q}",
        {bus.ready, bus.busy, bus.overrun, bus.q}, 0);
    rst_n = 1'b1;

    // All-0xA5 frame
    for (int i = 0; i < IMG_BYTES_C; i++) frame[i] = 8'hA5;
    send_frame();
    chk("busy_in_wait", bus.busy, 1);
    chk("overrun_clean_frame", bus.overrun, 0);
    apply_table(1);
    pulse_done();

    // Single set pixels at both ends of the image
    for (int i = 0; i < IMG_BYTES_C; i++) frame[i] = 8'h00;
    frame[0] = 8'h01;
    frame[IMG_BYTES_C-1] = 8'h80;
    send_frame();
    apply_table(2);
    pulse_done();

    // Bytes while the core owns the RAM are dropped
    rand_frame();
    send_frame();
    for (int i = 0; i < 3; i++) send_byte(8'hFF);
    chk("overrun_in_wait", bus.overrun, m_ovr);
    rand_reads(40);
    pulse_done();
    chk("overrun_sticky_idle", bus.overrun, 1);
    rand_frame();
    send_frame();
    chk("overrun_cleared", bus.overrun, m_ovr);
    rand_reads(40);
    pulse_done();

    // Back-to-back rx_rdy: second byte lands in UNPACK and is lost
    begin
      bit r;
      r = model_byte(8'h3C);
      m_ovr = 1;
      @(negedge clk); bus.rx_rdy = 1'b1; bus.rx_data = 8'h3C;
      @(negedge clk); bus.rx_data = 8'hC3;
      @(negedge clk); bus.rx_rdy = 1'b0;
      repeat (12) @(negedge clk);
      chk("overrun_unpack_drop", bus.overrun, 1);
      chk("busy_after_drop", bus.busy, 1);
      for (int i = 1; i < IMG_BYTES_C; i++) send_byte(8'($urandom));
      for (int i = 0; i < 8; i++) read_chk("byte0_kept", 10'(i), m_ram[i]);
      rand_reads(30);
      pulse_done();
    end

    // Reset in the middle of a frame
    for (int i = 0; i < 50; i++) send_byte(8'($urandom));
    bus.addr = 10'd0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("midframe_reset_outputs", {bus.ready, bus.busy, bus.overrun, bus.q}, 0);
    rst_n = 1'b1;
    m_idx = 0; m_locked = 0; m_ovr = 0;
    rand_frame();
    send_frame();
    rand_reads(60);
    pulse_done();

`ifdef LOADER_TIMEOUT_EN
    // Stall after byte 10 until the gap counter expires
    for (int i = 0; i < 11; i++) send_byte(8'($urandom));
    repeat (TO - 30) @(negedge clk);
    chk("busy_before_timeout", bus.busy, 1);
    repeat (40) @(negedge clk);
    m_idx = 0; m_ovr = 1;
    chk("busy_after_timeout", bus.busy, 0);
    chk("overrun_after_timeout", bus.overrun, 1);
    rand_frame();
    send_frame();
    rand_reads(30);
    pulse_done();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
